// File: rtl/neural_layer_backprop_if.sv
`default_nettype none
// ============================================================================
//  Module   : neural_layer_backprop_if
//  Purpose  : Bundles the start/done handshake and the data buses of the
//             2x2 neural-layer backward-pass engine.
//  Modports : master - drives start and all operands, observes results
//             slave  - the engine: takes operands, drives busy/done/results
//  Signals  : start, A, B, e1, e2, cAA, cAB, cBA, cBB, b1, b2, lr   (in)
//             busy, done, eA, eB, nAA, nAB, nBA, nBB, nb1, nb2     (out)
//  Revision : 1.0 - initial release
// ============================================================================
interface neural_layer_backprop_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
    logic [WIDTH-1:0] cAA;
    logic [WIDTH-1:0] cAB;
    logic [WIDTH-1:0] cBA;
    logic [WIDTH-1:0] cBB;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] b2;
    logic [WIDTH-1:0] lr;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] eA;
    logic [WIDTH-1:0] eB;
    logic [WIDTH-1:0] nAA;
    logic [WIDTH-1:0] nAB;
    logic [WIDTH-1:0] nBA;
    logic [WIDTH-1:0] nBB;
    logic [WIDTH-1:0] nb1;
    logic [WIDTH-1:0] nb2;

    modport master (
        output start, A, B, e1, e2, cAA, cAB, cBA, cBB, b1, b2, lr,
        input  busy, done, eA, eB, nAA, nAB, nBA, nBB, nb1, nb2
    );

    modport slave (
        input  start, A, B, e1, e2, cAA, cAB, cBA, cBB, b1, b2, lr,
        output busy, done, eA, eB, nAA, nAB, nBA, nBB, nb1, nb2
    );
endinterface
`default_nettype wire

// File: rtl/neural_layer_backprop.sv
`default_nettype none
// ============================================================================
//  Module   : neural_layer_backprop
//  Purpose  : Backward pass of the 2-input/2-output neural layer
//             (o1 = A*cAA + B*cBA + b1, o2 = A*cAB + B*cBB + b2).
//             Computes back-propagated errors eA/eB and gradient-descent
//             updated weights/biases with a single shared Q8.8 multiplier,
//             one multiply per cycle over 14 steps.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset
//             bus   - neural_layer_backprop_if.slave (handshake + data)
//  Options  : NEURAL_BP_SAT_EN - when defined, product and sum reductions
//             saturate to 16'h7FFF/16'h8000; otherwise they wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module neural_layer_backprop #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    neural_layer_backprop_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_last_step = 4'd13;

    state_t                   r_state;
    logic [3:0]               r_step;
    logic                     r_busy;
    logic                     r_done;

    // Operands captured at the launch edge
    logic signed [WIDTH-1:0]  r_a, r_b, r_e1, r_e2, r_lr;
    logic signed [WIDTH-1:0]  r_caa, r_cab, r_cba, r_cbb, r_b1, r_b2;

    // Scratch results
    logic signed [WIDTH-1:0]  r_acc;
    logic signed [WIDTH-1:0]  r_ea, r_eb, r_nb1;
    logic signed [WIDTH-1:0]  r_g [4];   // gAA, gBA, gAB, gBB
    logic signed [WIDTH-1:0]  r_n [4];   // nAA, nBA, nAB, nBB

    // Visible results, loaded only at completion
    logic [WIDTH-1:0]         r_out_ea, r_out_eb;
    logic [WIDTH-1:0]         r_out_naa, r_out_nab, r_out_nba, r_out_nbb;
    logic [WIDTH-1:0]         r_out_nb1, r_out_nb2;

    logic signed [WIDTH-1:0]  w_opa, w_opb, w_add;
    logic                     w_sub;
    logic signed [2*WIDTH-1:0] w_mul_full, w_mul_sh;
    logic signed [WIDTH-1:0]  w_prod;
    logic signed [WIDTH:0]    w_sum_full;
    logic signed [WIDTH-1:0]  w_sum;

    // Per-step operand selection for the multiplier and the adder.
    // Steps 1/3 finish eA/eB, steps 8..13 form c - lr*g and b - lr*e.
    always_comb begin
        w_opa = '0;
        w_opb = '0;
        w_add = r_acc;
        w_sub = 1'b0;
        case (r_step)
            4'd0:  begin w_opa = r_caa; w_opb = r_e1; end
            4'd1:  begin w_opa = r_cab; w_opb = r_e2; end
            4'd2:  begin w_opa = r_cba; w_opb = r_e1; end
            4'd3:  begin w_opa = r_cbb; w_opb = r_e2; end
            4'd4:  begin w_opa = r_e1;  w_opb = r_a;  end
            4'd5:  begin w_opa = r_e1;  w_opb = r_b;  end
            4'd6:  begin w_opa = r_e2;  w_opb = r_a;  end
            4'd7:  begin w_opa = r_e2;  w_opb = r_b;  end
            4'd8:  begin w_opa = r_lr;  w_opb = r_g[0]; w_add = r_caa; w_sub = 1'b1; end
            4'd9:  begin w_opa = r_lr;  w_opb = r_g[1]; w_add = r_cba; w_sub = 1'b1; end
            4'd10: begin w_opa = r_lr;  w_opb = r_g[2]; w_add = r_cab; w_sub = 1'b1; end
            4'd11: begin w_opa = r_lr;  w_opb = r_g[3]; w_add = r_cbb; w_sub = 1'b1; end
            4'd12: begin w_opa = r_lr;  w_opb = r_e1;   w_add = r_b1;  w_sub = 1'b1; end
            4'd13: begin w_opa = r_lr;  w_opb = r_e2;   w_add = r_b2;  w_sub = 1'b1; end
            default: ;
        endcase
    end

    assign w_mul_full = w_opa * w_opb;
    assign w_mul_sh   = w_mul_full >>> FRAC;   // floor toward -inf
    assign w_sum_full = w_sub ? ({w_add[WIDTH-1], w_add} - {w_prod[WIDTH-1], w_prod})
                              : ({w_add[WIDTH-1], w_add} + {w_prod[WIDTH-1], w_prod});

`ifdef NEURAL_BP_SAT_EN
    localparam logic [WIDTH-1:0] c_sat_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_sat_min = {1'b1, {(WIDTH-1){1'b0}}};

    logic w_prod_fits;
    logic w_sum_fits;

    // A value fits in WIDTH bits when every bit above the sign bit
    // is a copy of it.
    assign w_prod_fits = (&w_mul_sh[2*WIDTH-1:WIDTH-1]) | ~(|w_mul_sh[2*WIDTH-1:WIDTH-1]);
    assign w_sum_fits  = (w_sum_full[WIDTH] == w_sum_full[WIDTH-1]);

    assign w_prod = w_prod_fits ? w_mul_sh[WIDTH-1:0]
                  : (w_mul_sh[2*WIDTH-1] ? c_sat_min : c_sat_max);
    assign w_sum  = w_sum_fits ? w_sum_full[WIDTH-1:0]
                  : (w_sum_full[WIDTH] ? c_sat_min : c_sat_max);
`else
    logic w_unused_bits;

    assign w_prod = w_mul_sh[WIDTH-1:0];
    assign w_sum  = w_sum_full[WIDTH-1:0];
    assign w_unused_bits = ^{w_mul_sh[2*WIDTH-1:WIDTH], w_sum_full[WIDTH]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_step    <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_e1      <= '0;
            r_e2      <= '0;
            r_lr      <= '0;
            r_caa     <= '0;
            r_cab     <= '0;
            r_cba     <= '0;
            r_cbb     <= '0;
            r_b1      <= '0;
            r_b2      <= '0;
            r_acc     <= '0;
            r_ea      <= '0;
            r_eb      <= '0;
            r_nb1     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_g[i] <= '0;
                r_n[i] <= '0;
            end
            r_out_ea  <= '0;
            r_out_eb  <= '0;
            r_out_naa <= '0;
            r_out_nab <= '0;
            r_out_nba <= '0;
            r_out_nbb <= '0;
            r_out_nb1 <= '0;
            r_out_nb2 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_e1    <= bus.e1;
                        r_e2    <= bus.e2;
                        r_lr    <= bus.lr;
                        r_caa   <= bus.cAA;
                        r_cab   <= bus.cAB;
                        r_cba   <= bus.cBA;
                        r_cbb   <= bus.cBB;
                        r_b1    <= bus.b1;
                        r_b2    <= bus.b2;
                        r_step  <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end

                S_CALC: begin
                    case (r_step)
                        4'd0, 4'd2: r_acc <= w_prod;
                        4'd1:       r_ea  <= w_sum;
                        4'd3:       r_eb  <= w_sum;
                        4'd4:       r_g[0] <= w_prod;
                        4'd5:       r_g[1] <= w_prod;
                        4'd6:       r_g[2] <= w_prod;
                        4'd7:       r_g[3] <= w_prod;
                        4'd8:       r_n[0] <= w_sum;
                        4'd9:       r_n[1] <= w_sum;
                        4'd10:      r_n[2] <= w_sum;
                        4'd11:      r_n[3] <= w_sum;
                        4'd12:      r_nb1  <= w_sum;
                        default: ;
                    endcase

                    if (r_step == c_last_step) begin
                        // Every visible result changes on this one edge.
                        r_out_ea  <= r_ea;
                        r_out_eb  <= r_eb;
                        r_out_naa <= r_n[0];
                        r_out_nba <= r_n[1];
                        r_out_nab <= r_n[2];
                        r_out_nbb <= r_n[3];
                        r_out_nb1 <= r_nb1;
                        r_out_nb2 <= w_sum;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_step    <= 4'd0;
                        r_state   <= S_DONE;
                    end else begin
                        r_step    <= r_step + 4'd1;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.eA   = r_out_ea;
    assign bus.eB   = r_out_eb;
    assign bus.nAA  = r_out_naa;
    assign bus.nAB  = r_out_nab;
    assign bus.nBA  = r_out_nba;
    assign bus.nBB  = r_out_nbb;
    assign bus.nb1  = r_out_nb1;
    assign bus.nb2  = r_out_nb2;

endmodule
`default_nettype wire

// File: tb/tb_neural_layer_backprop.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neural_layer_backprop
//  Purpose  : Self-checking bench for neural_layer_backprop. A reference
//             model computes each result with plain integer arithmetic at
//             launch time and tracks the busy/done timeline; a compare
//             process checks the DUT against it every cycle. Directed
//             vectors add hand-computed literal checks.
//  Options  : honours NEURAL_BP_SAT_EN for the expected reduction mode.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_neural_layer_backprop;

    logic clk;
    logic rst_n;

    neural_layer_backprop_if #(.WIDTH(16)) bus ();

    neural_layer_backprop #(.WIDTH(16), .FRAC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ea, eb, naa, nab, nba, nbb, nb1, nb2;
    } res_t;

    int   n_vec = 0;
    int   n_err = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic signed [15:0] red(input longint v);
`ifdef NEURAL_BP_SAT_EN
        if (v > 32767)  return 16'sh7FFF;
        if (v < -32768) return 16'sh8000;
`endif
        return v[15:0];
    endfunction

    function automatic logic signed [15:0] mulq(input logic signed [15:0] x, input logic signed [15:0] y);
        longint p;
        p = longint'(x) * longint'(y);
        return red(p >>> 8);
    endfunction

    function automatic logic signed [15:0] addq(input logic signed [15:0] x, input logic signed [15:0] y);
        return red(longint'(x) + longint'(y));
    endfunction

    function automatic logic signed [15:0] subq(input logic signed [15:0] x, input logic signed [15:0] y);
        return red(longint'(x) - longint'(y));
    endfunction

    function automatic res_t model(input logic signed [15:0] a, b, e1, e2, caa, cab, cba, cbb, b1, b2, lr);
        res_t r;
        logic signed [15:0] gaa, gba, gab, gbb;
        gaa   = mulq(e1, a);
        gba   = mulq(e1, b);
        gab   = mulq(e2, a);
        gbb   = mulq(e2, b);
        r.ea  = addq(mulq(caa, e1), mulq(cab, e2));
        r.eb  = addq(mulq(cba, e1), mulq(cbb, e2));
        r.naa = subq(caa, mulq(lr, gaa));
        r.nba = subq(cba, mulq(lr, gba));
        r.nab = subq(cab, mulq(lr, gab));
        r.nbb = subq(cbb, mulq(lr, gbb));
        r.nb1 = subq(b1, mulq(lr, e1));
        r.nb2 = subq(b2, mulq(lr, e2));
        return r;
    endfunction

    // ---------------- timeline model ----------------
    // m_age counts edges since launch (0 = idle); result visible with
    // done at age 15, i.e. 14 edges after the launch edge.
    int   m_age;
    res_t m_pend;
    res_t m_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age  <= 0;
            m_pend <= '0;
            m_out  <= '0;
        end else if (m_age == 0) begin
            if (bus.start) begin
                m_age  <= 1;
                m_pend <= model(bus.A, bus.B, bus.e1, bus.e2, bus.cAA, bus.cAB,
                                bus.cBA, bus.cBB, bus.b1, bus.b2, bus.lr);
            end
        end else if (m_age == 14) begin
            m_out <= m_pend;
            m_age <= 15;
        end else if (m_age == 15) begin
            m_age <= 0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, bus.busy}, {31'd0, (m_age >= 1 && m_age <= 14)});
            check("done", {31'd0, bus.done}, {31'd0, (m_age == 15)});
            check("eA",  {16'd0, bus.eA},  {16'd0, m_out.ea});
            check("eB",  {16'd0, bus.eB},  {16'd0, m_out.eb});
            check("nAA", {16'd0, bus.nAA}, {16'd0, m_out.naa});
            check("nAB", {16'd0, bus.nAB}, {16'd0, m_out.nab});
            check("nBA", {16'd0, bus.nBA}, {16'd0, m_out.nba});
            check("nBB", {16'd0, bus.nBB}, {16'd0, m_out.nbb});
            check("nb1", {16'd0, bus.nb1}, {16'd0, m_out.nb1});
            check("nb2", {16'd0, bus.nb2}, {16'd0, m_out.nb2});
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic [15:0] a, b, e1, e2, caa, cab, cba, cbb, b1, b2, lr);
        bus.A = a;   bus.B = b;   bus.e1 = e1;   bus.e2 = e2;
        bus.cAA = caa; bus.cAB = cab; bus.cBA = cba; bus.cBB = cbb;
        bus.b1 = b1; bus.b2 = b2; bus.lr = lr;
    endtask

    // Called 2 time units after a rising edge while the DUT is idle.
    task automatic run_op(output int lat);
        lat = -1;
        bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        @(posedge clk);
        #2;
    endtask

    int   lat;
    int   nd;
    int   t_first, t_second;
    res_t pin;

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        set_in(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_eA",   {16'd0, bus.eA},   32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // lr = 0: weights and biases pass through unchanged
        set_in(16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0123, 16'h0456, 16'h0000);
        run_op(lat);
        check("t1_lat", lat, 14);
        check("t1_eA",  {16'd0, bus.eA},  32'h0100);
        check("t1_eB",  {16'd0, bus.eB},  32'h0000);
        check("t1_nAA", {16'd0, bus.nAA}, 32'h0100);
        check("t1_nBA", {16'd0, bus.nBA}, 32'h0000);
        check("t1_nb1", {16'd0, bus.nb1}, 32'h0123);
        check("t1_nb2", {16'd0, bus.nb2}, 32'h0456);

        // lr = 0.5
        set_in(16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0100, 16'h0080);
        pin = model(16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0100, 16'h0080);
        check("pin_nAA", {16'd0, pin.naa}, 32'h0080);
        check("pin_nBA", {16'd0, pin.nba}, 32'hFF80);
        run_op(lat);
        check("t2_lat", lat, 14);
        check("t2_nAA", {16'd0, bus.nAA}, 32'h0080);
        check("t2_nBA", {16'd0, bus.nBA}, 32'hFF80);
        check("t2_nAB", {16'd0, bus.nAB}, 32'h0000);
        check("t2_nBB", {16'd0, bus.nBB}, 32'h0000);
        check("t2_nb1", {16'd0, bus.nb1}, 32'h0080);
        check("t2_nb2", {16'd0, bus.nb2}, 32'h0100);
        check("t2_eA",  {16'd0, bus.eA},  32'h0100);

        // negative path, floor behaviour
        set_in(16'h0100, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h0000, 16'h0100);
        run_op(lat);
        check("t3_nAA", {16'd0, bus.nAA}, 32'h0001);
        check("t3_eA",  {16'd0, bus.eA},  32'h0000);
        check("t3_nb1", {16'd0, bus.nb1}, 32'h0001);

        // overflow
        set_in(16'h0000, 16'h0000, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000);
        pin = model(16'h0000, 16'h0000, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000);
        run_op(lat);
`ifdef NEURAL_BP_SAT_EN
        check("pin_ovf_eA", {16'd0, pin.ea}, 32'h7FFF);
        check("t4_eA", {16'd0, bus.eA}, 32'h7FFF);
`else
        check("pin_ovf_eA", {16'd0, pin.ea}, 32'h0200);
        check("t4_eA", {16'd0, bus.eA}, 32'h0200);
`endif

        // mixed-sign vectors checked by the model
        set_in(16'hFE80, 16'h0240, 16'h0033, 16'hFFA0, 16'hFF00, 16'h0180, 16'h00C0, 16'hFD00, 16'h0010, 16'hFFF0, 16'h0020);
        run_op(lat);
        check("t5_lat", lat, 14);
        set_in(16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF);
        run_op(lat);
        check("t6_lat", lat, 14);

        // extra start pulses during the run and in DONE are ignored
        set_in(16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0100, 16'h0080);
        nd = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) nd++;
            #1 bus.start = (k == 2 || k == 13 || k == 14);
        end
        bus.start = 1'b0;
        check("hs_single_done", nd, 1);

        // start held high: relaunch every 16 cycles, late input changes ignored
        nd = 0; t_first = -1; t_second = -1;
        bus.start = 1'b1;
        @(posedge clk);
        #2 set_in(16'h0200, 16'hFF00, 16'h0040, 16'h0100, 16'h0300, 16'hFF80, 16'h0010, 16'h0020, 16'h0050, 16'hFFB0, 16'h0100);
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                nd++;
                if (nd == 1) begin
                    t_first = k;
                    check("held_first_nAA", {16'd0, bus.nAA}, 32'h0080);
                    check("held_first_nb1", {16'd0, bus.nb1}, 32'h0080);
                end else if (nd == 2) begin
                    t_second = k;
                end
            end
        end
        bus.start = 1'b0;
        check("held_count", nd, 3);
        check("held_first", t_first, 14);
        check("held_spacing", t_second - t_first, 16);
        repeat (20) @(posedge clk);
        #2;

        // reset mid-run aborts with no done pulse
        set_in(16'h0100, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h0000, 16'h0100);
        bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rstmid_busy", {31'd0, bus.busy}, 32'd0);
        check("rstmid_done", {31'd0, bus.done}, 32'd0);
        check("rstmid_eA",   {16'd0, bus.eA},   32'h0);
        check("rstmid_nAA",  {16'd0, bus.nAA},  32'h0);
        check("rstmid_nb2",  {16'd0, bus.nb2},  32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        nd = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) nd++;
        end
        check("rstmid_no_done", nd, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/neural_layer_backprop.md
Name: neural_layer_backprop

Overview:
- Backward-pass counterpart of the 2-input/2-output NEURAL_LAYER.
- Forward convention, fixed for the codebase: o1 = A*cAA + B*cBA + b1; o2 = A*cAB + B*cBB + b2.
- Takes the layer inputs, current weights/biases, output errors e1/e2 and a learning rate. Produces the errors propagated to the previous layer (eA, eB) and gradient-descent-updated weights/biases.
- Uses one shared Q8.8 multiplier, sequenced by an FSM under a start/done handshake.

Parameters:
- WIDTH, 16, word width of all data ports (signed two's complement).
- FRAC, 8, fractional bits (Q8.8; 16'h0100 = 1.0).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse/level; sampled only in IDLE
- A, B  in  WIDTH  forward-pass layer inputs
- e1, e2  in  WIDTH  error at o1, o2
- cAA, cAB, cBA, cBB  in  WIDTH  current weights
- b1, b2  in  WIDTH  current biases
- lr  in  WIDTH  learning rate, Q8.8
- busy  out  1  high while computing
- done  out  1  one-cycle pulse when results are valid
- eA, eB  out  WIDTH  back-propagated errors
- nAA, nAB, nBA, nBB  out  WIDTH  updated weights
- nb1, nb2  out  WIDTH  updated biases

Behaviour:
- Reset (async, rst_n=0): state=IDLE, step=0, busy=0, done=0, all data outputs 16'h0000.
- Arithmetic: mul(x,y) = signed 32-bit product, arithmetic shift right by FRAC (floor), reduced to WIDTH. Sums use WIDTH+1 bits and are then reduced. Reduction method is set by the optional feature.
- Targets:
  - eA = mul(cAA,e1) + mul(cAB,e2)
  - eB = mul(cBA,e1) + mul(cBB,e2)
  - gAA = mul(e1,A), gBA = mul(e1,B), gAB = mul(e2,A), gBB = mul(e2,B)
  - nXY = cXY - mul(lr,gXY)
  - nb1 = b1 - mul(lr,e1); nb2 = b2 - mul(lr,e2)
- FSM states:
  - IDLE: start=1 at an edge latches all data inputs into internal registers, sets state=CALC, step=0, busy=1.
  - CALC: one multiply per cycle, steps 0..13, in this order: cAA*e1, cAB*e2, cBA*e1, cBB*e2, e1*A, e1*B, e2*A, e2*B, lr*gAA, lr*gBA, lr*gAB, lr*gBB, lr*e1, lr*e2. Results go to internal accumulators/scratch registers.
  - At the edge executing step 13: all outputs load simultaneously, done<=1, busy<=0, state=DONE.
  - DONE: lasts one cycle, then returns to IDLE with done<=0. Outputs hold until the next completion.
- Latency: done rises at the 14th rising edge after the edge that samples start. Minimum start-to-start spacing is 16 cycles.
- Input changes after the latch edge have no effect on the current operation.
- start while busy or in DONE is ignored; it is not queued. A start held high continuously re-launches from IDLE.
- Outputs never show partial results. They change only at the completion edge.
- Reset mid-operation aborts immediately to reset values. No done pulse is produced.

Optional Feature:
- NEURAL_BP_SAT_EN defined: every product reduction and sum reduction saturates to 16'h7FFF / 16'h8000 on overflow.
- Not defined: plain two's-complement truncation (wrap), keeping the low WIDTH bits.

Test Plan:
- Reset: assert rst_n=0 mid-run -> busy=0, done=0, all outputs 0000 immediately; no done pulse afterwards.
- lr=0000, A=B=0100, e1=0100, e2=0000, cAA=0100, others 0 -> eA=0100, eB=0000; n* equal inputs (nAA=0100, nAB=nBA=nBB=0000); nb1=b1, nb2=b2.
- lr=0080, A=B=0100, e1=0100, e2=0000, cAA=0100, cAB=cBA=cBB=0, b1=b2=0100 -> nAA=0080, nBA=FF80, nAB=0000, nBB=0000, nb1=0080, nb2=0100, eA=0100, eB=0000; done exactly 14 edges after start.
- Negative path: e1=FFFF (−1/256), A=0100, lr=0100, cAA=0000 -> gAA=FFFF, nAA=0001; eA=0000 (floor of 0*FFFF).
- Overflow: cAA=cAB=e1=e2=7F00 -> with NEURAL_BP_SAT_EN eA=7FFF; without it eA=0200.
- Handshake: pulse start again at cycles 3 and 14 of a run -> ignored, single done pulse. Start held high -> done every 16 cycles; inputs changed after the latch edge do not affect that result.
